// File: rtl/kyber_axi_rd_master.sv
// AXI4 read master: splits a (start address, beat count) command into 4KB-safe INCR bursts
// and streams the 128-bit beats through a 2-entry registered FIFO. Optional watchdog: KYBER_RD_TIMEOUT_EN.
module kyber_axi_rd_master #(
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic         s_axi_aclk,
    input  logic         s_axi_aresetn,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [16:0]  cmd_addr,
    input  logic [7:0]   cmd_len,
    output logic [127:0] dout_data,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         dout_last,
    output logic         done,
    output logic         err,
    output logic [16:0]  m_axi_araddr,
    output logic [7:0]   m_axi_arlen,
    output logic [2:0]   m_axi_arsize,
    output logic [1:0]   m_axi_arburst,
    output logic         m_axi_arvalid,
    input  logic         m_axi_arready,
    input  logic [127:0] m_axi_rdata,
    input  logic [1:0]   m_axi_rresp,
    input  logic         m_axi_rlast,
    input  logic         m_axi_rvalid,
    output logic         m_axi_rready
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN} state_t;

    localparam logic [8:0] MAXB = 9'(MAX_BURST);

    state_t       r_state;
    state_t       w_next;
    logic [16:0]  r_addr;
    logic [8:0]   r_remaining;
    logic [8:0]   r_burst_cnt;
    logic [8:0]   r_beats;
    logic         r_err;
    logic [127:0] r_fifo_data [2];
    logic [1:0]   r_fifo_last;
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    logic         w_cmd_hs;
    logic         w_ar_hs;
    logic         w_r_hs;
    logic         w_pop;
    logic [8:0]   w_room;
    logic [8:0]   w_beats;
    logic         w_burst_end;
    logic         w_beat_err;
    logic         w_timeout;
    logic         w_unused;

    // Beats left before the next 4KB page; the address is always 16-byte aligned.
    always_comb begin
        w_room  = 9'd256 - {1'b0, r_addr[11:4]};
        w_beats = r_remaining;
        if (MAXB < w_beats) w_beats = MAXB;
        if (w_room < w_beats) w_beats = w_room;
    end

    assign cmd_ready     = (r_state == S_IDLE) & s_axi_aresetn;
    assign m_axi_arvalid = (r_state == S_ADDR);
    assign m_axi_araddr  = m_axi_arvalid ? r_addr : 17'd0;
    assign m_axi_arlen   = m_axi_arvalid ? 8'(w_beats - 9'd1) : 8'd0;
    assign m_axi_arsize  = m_axi_arvalid ? 3'b100 : 3'b000;
    assign m_axi_arburst = m_axi_arvalid ? 2'b01 : 2'b00;
    assign m_axi_rready  = (r_state == S_DATA) & (r_count != 2'd2) & ~w_timeout;

    assign w_cmd_hs    = cmd_valid & cmd_ready;
    assign w_ar_hs     = m_axi_arvalid & m_axi_arready;
    assign w_r_hs      = m_axi_rvalid & m_axi_rready;
    assign w_burst_end = w_r_hs & (r_burst_cnt == 9'd1);
    assign w_beat_err  = w_r_hs & (m_axi_rresp[1] | (m_axi_rlast != (r_burst_cnt == 9'd1)));

    assign dout_valid = (r_count != 2'd0);
    assign dout_data  = r_fifo_data[r_rd_ptr];
    assign dout_last  = dout_valid & r_fifo_last[r_rd_ptr];
    assign w_pop      = dout_valid & dout_ready;

    assign done = (r_state == S_DRAIN) & (r_count == 2'd0);
    assign err  = done & r_err;

    assign w_unused = ^{m_axi_rresp[0], cmd_addr[3:0]};

`ifdef KYBER_RD_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] r_wdog;
    logic            w_busy;

    assign w_busy    = (r_state == S_ADDR) | (r_state == S_DATA);
    assign w_timeout = w_busy & (r_wdog == WD_W'(TIMEOUT));

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            r_wdog <= '0;
        end else if (!w_busy || w_ar_hs || w_r_hs) begin
            r_wdog <= '0;
        end else if (!w_timeout) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end
`else
    // Constant false: without the watchdog the master waits on the slave forever.
    assign w_timeout = (TIMEOUT < 0);
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (cmd_valid) w_next = S_ADDR;
            S_ADDR: begin
                if (w_timeout)          w_next = S_DRAIN;
                else if (m_axi_arready) w_next = S_DATA;
            end
            S_DATA: begin
                if (w_timeout)        w_next = S_DRAIN;
                else if (w_burst_end) w_next = (r_remaining == 9'd1) ? S_DRAIN : S_ADDR;
            end
            S_DRAIN: if (r_count == 2'd0) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_burst_cnt <= '0;
            r_beats     <= '0;
            r_err       <= 1'b0;
            r_fifo_last <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state <= w_next;
            if (w_cmd_hs) begin
                r_addr      <= {cmd_addr[16:4], 4'h0};
                r_remaining <= {1'b0, cmd_len} + 9'd1;
                r_err       <= 1'b0;
            end
            if (w_ar_hs) begin
                r_burst_cnt <= w_beats;
                r_beats     <= w_beats;
            end
            if (w_r_hs) begin
                r_burst_cnt             <= r_burst_cnt - 9'd1;
                r_remaining             <= r_remaining - 9'd1;
                r_fifo_last[r_wr_ptr]   <= (r_remaining == 9'd1);
                r_wr_ptr                <= ~r_wr_ptr;
            end
            if (w_beat_err || w_timeout) r_err <= 1'b1;
            if (w_burst_end) r_addr <= r_addr + {4'h0, r_beats, 4'h0};
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_r_hs} - {1'b0, w_pop};
        end
    end

    // Payload storage carries no reset; occupancy is tracked by r_count.
    always_ff @(posedge s_axi_aclk) begin
        if (w_r_hs) r_fifo_data[r_wr_ptr] <= m_axi_rdata;
    end

endmodule

// File: doc/kyber_axi_rd_master.md
KYBER_AXI_RD_MASTER -- requirements
Module: kyber_axi_rd_master

Interface
REQ-001 SHALL have parameter MAX_BURST, default 16, meaning maximum beats per AR burst (1..256).
REQ-002 SHALL have parameter TIMEOUT, default 1024, meaning the watchdog limit in cycles (used only under KYBER_RD_TIMEOUT_EN).
REQ-003 SHALL have port s_axi_aclk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port s_axi_aresetn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port cmd_valid  in  1  command request.
REQ-006 SHALL have port cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_addr  in  17  start byte address; bits[3:0] ignored, treated as 0.
REQ-008 SHALL have port cmd_len  in  8  total beats minus 1 (1..256 beats).
REQ-009 SHALL have port dout_data  out  128  read beat to the consumer.
REQ-010 SHALL have port dout_valid  out  1  dout_data valid.
REQ-011 SHALL have port dout_ready  in  1  consumer accepts the beat.
REQ-012 SHALL have port dout_last  out  1  final beat of the command.
REQ-013 SHALL have port done  out  1  one-cycle completion pulse.
REQ-014 SHALL have port err  out  1  error status, valid only while done=1.
REQ-015 SHALL have port m_axi_araddr / m_axi_arlen / m_axi_arsize / m_axi_arburst  out  17/8/3/2  AR payload.
REQ-016 SHALL have port m_axi_arvalid  out  1, m_axi_arready  in  1  AR handshake.
REQ-017 SHALL have port m_axi_rdata / m_axi_rresp / m_axi_rlast / m_axi_rvalid  in  128/2/1/1  R channel.
REQ-018 SHALL have port m_axi_rready  out  1  R handshake.

Function
REQ-019 SHALL implement FSM IDLE -> ADDR -> DATA -> (ADDR | DRAIN) -> IDLE; exactly one AR outstanding at any time.
REQ-020 IDLE: cmd_ready=1; on handshake, latch the address with [3:0]=0, set remaining=cmd_len+1, clear err_flag, go to ADDR; m_axi_arvalid SHALL rise the next cycle.
REQ-021 ADDR: burst beats = min(remaining, MAX_BURST, (4096-addr[11:0])/16); arlen=beats-1, arsize=3'b100, arburst=2'b01 (INCR); payload held stable while arvalid=1 and arready=0; go to DATA on handshake.
REQ-022 DATA: rready=1 iff the 2-entry output FIFO holds fewer than 2 entries; each rvalid&rready pushes rdata and decrements burst and remaining counters.
REQ-023 The burst ends on the beat counter; rlast arriving early or missing on the counted last beat SHALL set err_flag.
REQ-024 Any beat with rresp[1]=1 (SLVERR/DECERR) SHALL set err_flag; data SHALL still be delivered.
REQ-025 At burst end, addr += beats*16 (17-bit wrap); remaining>0 -> ADDR, else DRAIN.
REQ-026 The FIFO is registered: data appears on dout_valid no earlier than the cycle after the R handshake, in order, with no loss under any dout_ready pattern; dout_last=1 only on the command's final beat.
REQ-027 DRAIN: wait for the FIFO to empty, then pulse done for 1 cycle with err=err_flag, and return to IDLE; cmd_ready SHALL be 0 outside IDLE.

Reset
REQ-028 While s_axi_aresetn=0 at a clock edge: state=IDLE, FIFO empty, counters 0; cmd_ready, dout_valid, dout_last, done, err, m_axi_arvalid and m_axi_rready SHALL be 0, and AR payload outputs SHALL be 0.
REQ-029 Reset mid-command SHALL abandon it silently (no done); cmd_ready=1 on the first cycle after release.

Configuration
REQ-030 With KYBER_RD_TIMEOUT_EN defined: a watchdog counts cycles in ADDR/DATA since the last AR or R handshake; at TIMEOUT it SHALL set err_flag, force rready=0, and go to DRAIN with dout_last never asserted.
REQ-031 Without KYBER_RD_TIMEOUT_EN: no watchdog logic; the block waits indefinitely; TIMEOUT is unused.

Verification
REQ-032 addr 0x10000, len 3, dout_ready=1 -> one AR (0x10000, arlen 3); 4 beats out, dout_last on the 4th; done=1, err=0.
REQ-033 addr 0x10000, len 39 -> ARs (0x10000,15), (0x10100,15), (0x10200,7); 40 beats in order.
REQ-034 addr 0x10FC0, len 7 -> ARs (0x10FC0,3), (0x11000,3); no burst crosses the 4KB boundary.
REQ-035 dout_ready=0 for 20 cycles mid-burst -> rready falls after 2 buffered beats; all beats are delivered in order once dout_ready=1.
REQ-036 rresp=2'b10 on beat 2 of 4 -> all 4 beats delivered, then done=1 with err=1.
REQ-037 Macro defined, rvalid withheld 1024 cycles -> done=1 with err=1 after drain; macro undefined -> FSM remains in DATA.
